adat_frame_writer_ctrl: RTL

- Write-side controller for the ADAT-to-I2S circular frame buffer.
- Takes the recovered ADAT bit stream and writes 256-bit frames into frame slots of the dual-port RAM.
- Publishes the newest complete frame index (last_good_frame_idx) and the resync request to the I2S MSB transmitter.
- Prevents the writer from overrunning the slot the transmitter is reading.

---
 rtl/adat_frame_writer_ctrl_pkg.sv | 15 +
 rtl/adat_frame_writer_ctrl_if.sv | 24 ++
 rtl/adat_frame_writer_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/adat_frame_writer_ctrl_pkg.sv
// Shared constants and writer state encoding for the ADAT-to-I2S frame buffer.
// The I2S transmitter is expected to import the same constants.
package adat_buf_pkg;

   localparam int unsigned FRAME_BITS            = 256;
   localparam int unsigned FRAME_IDX_BITS        = 8;
   localparam int unsigned DEFAULT_CIRC_BUF_BITS = 3;

   typedef enum logic [1:0] {
      StIdle,
      StWaitSync,
      StCapture
   } writer_state_e;

endpackage

// File: rtl/adat_frame_writer_ctrl_if.sv
// Write port of the circular frame RAM: {slot, bit index} address, one data bit, enable.
interface adat_frame_writer_ctrl_if
   import adat_buf_pkg::*;
#(
   parameter int unsigned CIRC_BUF_BITS = DEFAULT_CIRC_BUF_BITS
) ();

   logic [CIRC_BUF_BITS+FRAME_IDX_BITS-1:0] ram_write_addr;
   logic                                    ram_write_data;
   logic                                    ram_write_en;

   modport master (
      output ram_write_addr,
      output ram_write_data,
      output ram_write_en
   );

   modport slave (
      input ram_write_addr,
      input ram_write_data,
      input ram_write_en
   );

endinterface

// File: rtl/adat_frame_writer_ctrl.sv
// Writes recovered ADAT bits into 256-bit frame slots, publishes the newest complete
// slot and refuses to commit into the slot the I2S transmitter is reading.
module adat_frame_writer_ctrl
   import adat_buf_pkg::*;
#(
   parameter int unsigned CIRC_BUF_BITS = DEFAULT_CIRC_BUF_BITS,
   parameter int unsigned LOCK_FRAMES   = 8
) (
   input  logic                     clk_x4_i,
   input  logic                     rst_i,
   input  logic                     adat_locked_i,
   input  logic                     bit_valid_i,
   input  logic                     bit_data_i,
   input  logic                     frame_sync_i,
   input  logic [CIRC_BUF_BITS-1:0] read_frame_i,
   adat_frame_writer_ctrl_if.master ram_write,
   output logic [CIRC_BUF_BITS-1:0] last_good_frame_idx_o,
   output logic                     resync_req_o,
   output logic                     frame_error_o,
   output logic                     overrun_o
);

   localparam logic [FRAME_IDX_BITS-1:0] LAST_IDX  = FRAME_IDX_BITS'(FRAME_BITS - 1);
   localparam logic [7:0]                LOCK_CNT  = 8'(LOCK_FRAMES);
   localparam logic [CIRC_BUF_BITS-1:0]  SLOT_INIT = CIRC_BUF_BITS'(1);

   writer_state_e                            state_q, state_d;
   logic [CIRC_BUF_BITS-1:0]                 slot_q, slot_d;
   logic [FRAME_IDX_BITS-1:0]                idx_q, idx_d;
   logic [7:0]                               good_q, good_d;
   logic [CIRC_BUF_BITS-1:0]                 last_q, last_d;
   logic                                     resync_q, resync_d;
   logic                                     we_q, we_d;
   logic [CIRC_BUF_BITS+FRAME_IDX_BITS-1:0]  waddr_q, waddr_d;
   logic                                     wdata_q, wdata_d;
   logic                                     ferr_q, ferr_d;
   logic                                     ovr_q, ovr_d;

   logic                                     accept;
   logic [FRAME_IDX_BITS-1:0]                bit_idx;
   logic [CIRC_BUF_BITS-1:0]                 slot_next;

   always_ff @(posedge clk_x4_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         slot_q   <= SLOT_INIT;
         idx_q    <= '0;
         good_q   <= '0;
         last_q   <= '0;
         resync_q <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         slot_q   <= slot_d;
         idx_q    <= idx_d;
         good_q   <= good_d;
         last_q   <= last_d;
         resync_q <= resync_d;
         we_q     <= we_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      idx_d     = idx_q;
      good_d    = good_q;
      last_d    = last_q;
      resync_d  = resync_q | (good_q >= LOCK_CNT);
      we_d      = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      ferr_d    = 1'b0;
      ovr_d     = 1'b0;
      accept    = 1'b0;
      bit_idx   = frame_sync_i ? '0 : idx_q;
      slot_next = slot_q + SLOT_INIT;

      if (!adat_locked_i) begin
         // Partial frame is dropped silently; slot and published index survive.
         state_d  = StIdle;
         good_d   = '0;
         resync_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: state_d = StWaitSync;
            StWaitSync: begin
               if (frame_sync_i) begin
                  idx_d   = '0;
                  state_d = StCapture;
                  accept  = bit_valid_i;
               end
            end
            StCapture: begin
               if (frame_sync_i) begin
                  if (idx_q != '0) begin
                     ferr_d = 1'b1;
                     good_d = '0;
                  end
                  idx_d = '0;
               end
               accept = bit_valid_i;
            end
            default: state_d = StIdle;
         endcase
      end

      if (accept) begin
         we_d    = 1'b1;
         waddr_d = {slot_q, bit_idx};
         wdata_d = bit_data_i;
         idx_d   = bit_idx + 1'b1;
         if (bit_idx == LAST_IDX) begin
            state_d = StWaitSync;
            // Next slot equal to the read slot means the frame stays unpublished and is rewritten.
            if (slot_next != read_frame_i) begin
               last_d = slot_q;
               slot_d = slot_next;
               good_d = (good_q == 8'hFF) ? good_q : good_q + 8'd1;
            end else begin
               ovr_d = 1'b1;
            end
         end
      end
   end

   assign ram_write.ram_write_addr = waddr_q;
   assign ram_write.ram_write_data = wdata_q;
   assign ram_write.ram_write_en   = we_q;
   assign last_good_frame_idx_o    = last_q;
   assign resync_req_o             = resync_q;
   assign frame_error_o            = ferr_q;
   assign overrun_o                = ovr_q;

endmodule
